// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit.
//   OP_W : width of the operation code
//   op_e : operation encodings (AND, OR, XOR, NOT, MUX, DMUX, ACCX, CLRACC)
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NOT    = 3'b011,
    OP_MUX    = 3'b100,
    OP_DMUX   = 3'b101,
    OP_ACCX   = 3'b110,
    OP_CLRACC = 3'b111
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational operation datapath of the logic unit.
// Ports:
//   op       : operation code (op_e encoding)
//   a, b     : WIDTH-bit operands; b[SELW-1:0] is the MUX/DMUX index
//   acc      : current XOR accumulator value
//   result   : operation result
//   acc_next : accumulator value if this operation is committed
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_next
);

  op_e             opc;
  logic [SELW-1:0] idx;
  logic            idx_ok;

  always_comb begin
    opc      = op_e'(op);
    idx      = b[SELW-1:0];
    // Only reachable when WIDTH is not a power of two.
    idx_ok   = (32'(idx) < 32'(WIDTH));
    result   = '0;
    acc_next = acc;
    case (opc)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_MUX:  if (idx_ok) result[0] = a[idx];
      OP_DMUX: if (idx_ok) result[idx] = a[0];
      OP_ACCX: begin
        acc_next = acc ^ a;
        result   = acc ^ a;
      end
      OP_CLRACC: begin
        acc_next = '0;
        result   = '0;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with XOR accumulator and valid/ready
// handshakes on both sides.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : upstream handshake
//   op, a, b            : operation code and operands
//   out_valid, out_ready: downstream handshake
//   result, zero, parity: registered result with zero / XOR-reduction flags
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: computed result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  // Running checksum
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] core_acc_next;

  logic_unit_core #(
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_core (
    .op       (s1_op_q),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .acc      (acc_q),
    .result   (core_result),
    .acc_next (core_acc_next)
  );

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // The accumulator commits only when its op moves into S2, so a stalled
  // ACCX/CLRACC sitting in S1 is never applied twice.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    acc_d      = acc_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      result_d   = core_result;
      zero_d     = ~|core_result;
      parity_d   = ^core_result;
      acc_d      = core_acc_next;
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // WIDTH=8 instance
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       zero;
  logic       parity;

  // WIDTH=6 instance
  logic       in_valid6 = 1'b0;
  logic       in_ready6;
  logic [2:0] op6 = '0;
  logic [5:0] a6 = '0;
  logic [5:0] b6 = '0;
  logic       out_valid6;
  logic [5:0] result6;
  logic       zero6;
  logic       parity6;

  int errors = 0;
  int checks = 0;

  logic [2:0] t_op  [6];
  logic [7:0] t_a   [6];
  logic [7:0] t_exp [6];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity)
  );

  logic_unit_pipe #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
    .op(op6), .a(a6), .b(b6), .out_valid(out_valid6), .out_ready(1'b1),
    .result(result6), .zero(zero6), .parity(parity6)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] r,
                         input logic z, input logic p);
    check({tag, ".valid"},  64'(out_valid), 64'(v));
    check({tag, ".result"}, 64'(result),    64'(r));
    check({tag, ".zero"},   64'(zero),      64'(z));
    check({tag, ".parity"}, 64'(parity),    64'(p));
  endtask

  task automatic chk_out6(input string tag, input logic [5:0] r, input logic z);
    check({tag, ".valid"},  64'(out_valid6), 64'd1);
    check({tag, ".result"}, 64'(result6),    64'(r));
    check({tag, ".zero"},   64'(zero6),      64'(z));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic drive6(input logic [2:0] o, input logic [5:0] x, input logic [5:0] y);
    in_valid6 = 1'b1;
    op6       = o;
    a6        = x;
    b6        = y;
  endtask

  initial begin
    int   sent;
    int   got;
    logic fire;
    logic cons;

    t_op[0] = OP_CLRACC; t_a[0] = 8'h00; t_exp[0] = 8'h00;
    t_op[1] = OP_ACCX;   t_a[1] = 8'h0F; t_exp[1] = 8'h0F;
    t_op[2] = OP_ACCX;   t_a[2] = 8'hF0; t_exp[2] = 8'hFF;
    t_op[3] = OP_ACCX;   t_a[3] = 8'hFF; t_exp[3] = 8'h00;
    t_op[4] = OP_CLRACC; t_a[4] = 8'h00; t_exp[4] = 8'h00;
    t_op[5] = OP_ACCX;   t_a[5] = 8'h01; t_exp[5] = 8'h01;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 8'h00, 1'b1, 1'b0);
    check("reset.in_ready", 64'(in_ready), 64'd1);

    // Single AND, 2-cycle latency
    drive(OP_AND, 8'hF0, 8'h3C);
    check("and.in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("and.lat1_valid", 64'(out_valid), 64'd0);
    tick();
    chk_out("and", 1'b1, 8'h30, 1'b0, 1'b0);
    tick();
    check("and.drained", 64'(out_valid), 64'd0);

    // Back-to-back XOR / NOT / OR, no bubbles
    drive(OP_XOR, 8'hAA, 8'hFF);
    tick();
    drive(OP_NOT, 8'h0F, 8'h5A);
    tick();
    chk_out("xor", 1'b1, 8'h55, 1'b0, 1'b0);
    drive(OP_OR, 8'h00, 8'h00);
    tick();
    chk_out("not", 1'b1, 8'hF0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("or0", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    check("b2b.drained", 64'(out_valid), 64'd0);

    // MUX / DMUX at WIDTH=8
    drive(OP_MUX, 8'h04, 8'h02);
    tick();
    drive(OP_DMUX, 8'h01, 8'h05);
    tick();
    chk_out("mux", 1'b1, 8'h01, 1'b0, 1'b1);
    drive(OP_DMUX, 8'h00, 8'h05);
    tick();
    chk_out("dmux1", 1'b1, 8'h20, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_out("dmux0", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();

    // MUX / DMUX at WIDTH=6, including out-of-range indices
    drive6(OP_MUX, 6'h3F, 6'h07);
    tick();
    drive6(OP_MUX, 6'h20, 6'h05);
    tick();
    chk_out6("w6.mux_oor", 6'h00, 1'b1);
    drive6(OP_DMUX, 6'h01, 6'h06);
    tick();
    chk_out6("w6.mux5", 6'h01, 1'b0);
    drive6(OP_DMUX, 6'h01, 6'h04);
    tick();
    chk_out6("w6.dmux_oor", 6'h00, 1'b1);
    in_valid6 = 1'b0;
    tick();
    chk_out6("w6.dmux4", 6'h10, 1'b0);
    tick();

    // Accumulator, streaming with out_ready high
    drive(OP_ACCX, 8'h0F, 8'h00);
    tick();
    drive(OP_ACCX, 8'hF0, 8'h00);
    tick();
    chk_out("acc0F", 1'b1, 8'h0F, 1'b0, 1'b0);
    drive(OP_ACCX, 8'hFF, 8'h00);
    tick();
    chk_out("accFF", 1'b1, 8'hFF, 1'b0, 1'b0);
    drive(OP_CLRACC, 8'hA5, 8'h00);
    tick();
    chk_out("acc00", 1'b1, 8'h00, 1'b1, 1'b0);
    drive(OP_ACCX, 8'h01, 8'h00);
    tick();
    chk_out("accclr", 1'b1, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("acc01", 1'b1, 8'h01, 1'b0, 1'b1);
    tick();

    // Same accumulator sequence with out_ready toggling
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      out_ready = ((cyc % 3) != 0);
      if (sent < 6) drive(t_op[sent], t_a[sent], 8'h00);
      else in_valid = 1'b0;
      #1;
      fire = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        check("acc_tog", 64'(result), 64'(t_exp[got]));
        got++;
      end
      tick();
      if (fire) sent++;
    end
    check("acc_tog.count", 64'(got), 64'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("acc_tog.drained", 64'(out_valid), 64'd0);

    // Backpressure: two accepted, third refused, output held
    out_ready = 1'b0;
    drive(OP_AND, 8'hFF, 8'h11);
    tick();
    check("bp.ready1", 64'(in_ready), 64'd1);
    drive(OP_AND, 8'hFF, 8'h22);
    tick();
    check("bp.full_ready", 64'(in_ready), 64'd0);
    chk_out("bp.hold0", 1'b1, 8'h11, 1'b0, 1'b0);
    drive(OP_AND, 8'hFF, 8'h44);
    tick();
    check("bp.full_ready2", 64'(in_ready), 64'd0);
    chk_out("bp.hold1", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    chk_out("bp.hold2", 1'b1, 8'h11, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp.second", 1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    check("bp.empty", 64'(out_valid), 64'd0);
    check("bp.empty_ready", 64'(in_ready), 64'd1);

    // Reset with two transactions buffered and acc=0x5A
    drive(OP_CLRACC, 8'h00, 8'h00);
    tick();
    drive(OP_ACCX, 8'h5A, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("pre_rst.acc", 1'b1, 8'h5A, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(OP_OR, 8'h12, 8'h00);
    tick();
    drive(OP_OR, 8'h34, 8'h00);
    tick();
    in_valid = 1'b0;
    check("pre_rst.full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst_mid", 1'b0, 8'h00, 1'b1, 1'b0);
    check("rst_mid.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drive(OP_ACCX, 8'h01, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("post_rst.acc", 1'b1, 8'h01, 1'b0, 1'b1);
    tick();
    check("post_rst.drained", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
